// File: rtl/qosc_pkg.sv
// qosc_pkg: shared FSM encoding, fixed-point constants and the 8-bit saturator for the quadrature oscillator.
package qosc_pkg;
    localparam int FRAC = 7;
    localparam int RND  = 64;

    typedef logic [3:0] state_t;
    localparam state_t S_IDLE  = 4'd0;
    localparam state_t S_MRR   = 4'd1;
    localparam state_t S_MII   = 4'd2;
    localparam state_t S_MRI   = 4'd3;
    localparam state_t S_MIR   = 4'd4;
    localparam state_t S_ROUND = 4'd5;
    localparam state_t S_SQR   = 4'd6;
    localparam state_t S_SQI   = 4'd7;
    localparam state_t S_AGC   = 4'd8;

    function automatic logic signed [7:0] sat8(input logic signed [17:0] x);
        return (x > 18'sd127) ? 8'h7f : (x < -18'sd128) ? 8'h80 : x[7:0];
    endfunction
endpackage

// File: rtl/qosc_mac.sv
// qosc_mac: single 8x8 signed multiplier feeding an 18-bit accumulator with clear and add/subtract control.
module qosc_mac (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    input  logic               sub,
    input  logic signed [7:0]  a,
    input  logic signed [7:0]  b,
    output logic signed [17:0] acc
);
    logic signed [15:0] prod;
    logic signed [17:0] base;
    assign prod = a * b;
    assign base = clr ? '0 : acc;
    always_ff @(posedge clk or posedge reset)
        if (reset)
            acc <= '0;
        else if (en)
            acc <= sub ? base - 18'(prod) : base + 18'(prod);
endmodule

// File: rtl/qosc_rotator.sv
// qosc_rotator: oscillator core advancing z <= z*c per accepted tick on one shared multiplier.
// Define QOSC_AGC_EN to add the amplitude-correction step towards the target power.
module qosc_rotator
    import qosc_pkg::*;
#(
    parameter int AGC_SHIFT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       tick,
    input  logic [7:0] init_re,
    input  logic [7:0] init_im,
    input  logic [7:0] re_coeff,
    input  logic [7:0] im_coeff,
    input  logic [7:0] power,
    output logic [7:0] out_re,
    output logic [7:0] out_im,
    output logic       valid,
    output logic       busy,
    output logic       overrun
);
    state_t             state;
    logic signed [7:0]  z_re, z_im, cr, ci, a, b, rnd_re, rnd_im;
    logic signed [17:0] acc, acc_re, sum_re, sum_im;
    logic               mac_en, mac_clr, mac_sub;

    assign busy = state != S_IDLE;

    // z is re-read for the squares after ROUND has overwritten it with z'
    always_comb begin
        a       = (state == S_MRR || state == S_MRI || state == S_SQR) ? z_re : z_im;
        b       = (state == S_MRR || state == S_MIR) ? cr : (state == S_MII || state == S_MRI) ? ci : a;
        mac_en  = state inside {S_MRR, S_MII, S_MRI, S_MIR, S_SQR, S_SQI};
        mac_clr = state inside {S_MRR, S_MRI, S_SQR};
        mac_sub = state == S_MII;
    end

    qosc_mac u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (mac_en),
        .clr   (mac_clr),
        .sub   (mac_sub),
        .a     (a),
        .b     (b),
        .acc   (acc)
    );

    assign sum_re = acc_re + 18'(RND);
    assign sum_im = acc + 18'(RND);
    assign rnd_re = sat8(sum_re >>> FRAC);
    assign rnd_im = sat8(sum_im >>> FRAC);

`ifdef QOSC_AGC_EN
    logic [7:0]        power_q;
    logic [16:0]       mag2, target;
    logic signed [7:0] step_re, step_im, agc_re, agc_im;
    assign mag2    = acc[16:0];
    assign target  = {3'b0, power_q, 6'b0};
    assign step_re = z_re >>> AGC_SHIFT;
    assign step_im = z_im >>> AGC_SHIFT;
    always_comb begin
        agc_re = (mag2 < target) ? sat8(18'(z_re) + 18'(step_re)) :
                 (mag2 > target) ? sat8(18'(z_re) - 18'(step_re)) : z_re;
        agc_im = (mag2 < target) ? sat8(18'(z_im) + 18'(step_im)) :
                 (mag2 > target) ? sat8(18'(z_im) - 18'(step_im)) : z_im;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^power ^ (AGC_SHIFT == 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            z_re    <= '0;
            z_im    <= '0;
            cr      <= '0;
            ci      <= '0;
            acc_re  <= '0;
            out_re  <= '0;
            out_im  <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
`ifdef QOSC_AGC_EN
            power_q <= '0;
`endif
        end else if (restart) begin
            state   <= S_IDLE;
            z_re    <= init_re;
            z_im    <= init_im;
            out_re  <= init_re;
            out_im  <= init_im;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (tick && busy)
                overrun <= 1'b1;
            case (state)
                S_IDLE: if (tick) begin
                    cr    <= re_coeff;
                    ci    <= im_coeff;
`ifdef QOSC_AGC_EN
                    power_q <= power;
`endif
                    state <= S_MRR;
                end
                S_MRR: state <= S_MII;
                S_MII: state <= S_MRI;
                S_MRI: begin
                    acc_re <= acc;
                    state  <= S_MIR;
                end
                S_MIR: state <= S_ROUND;
                S_ROUND: begin
                    z_re <= rnd_re;
                    z_im <= rnd_im;
`ifdef QOSC_AGC_EN
                    state <= S_SQR;
`else
                    out_re <= rnd_re;
                    out_im <= rnd_im;
                    valid  <= 1'b1;
                    state  <= S_IDLE;
`endif
                end
`ifdef QOSC_AGC_EN
                S_SQR: state <= S_SQI;
                S_SQI: state <= S_AGC;
                S_AGC: begin
                    z_re   <= agc_re;
                    z_im   <= agc_im;
                    out_re <= agc_re;
                    out_im <= agc_im;
                    valid  <= 1'b1;
                    state  <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qosc_rotator.sv
// tb_qosc_rotator: directed and randomized checks of qosc_rotator against an arithmetic reference model.
module tb_qosc_rotator;
    localparam int SH = 4;
`ifdef QOSC_AGC_EN
    localparam int LAT = 8;
    localparam bit AGC = 1'b1;
`else
    localparam int LAT = 5;
    localparam bit AGC = 1'b0;
`endif

    logic       clk = 1'b0, reset = 1'b1, restart = 1'b0, tick = 1'b0;
    logic [7:0] init_re = '0, init_im = '0, re_coeff = '0, im_coeff = '0, power = '0;
    logic [7:0] out_re, out_im;
    logic       valid, busy, overrun;
    logic [7:0] zr = '0, zi = '0;
    int         tests = 0, failed = 0;

    always #5 clk = ~clk;

    qosc_rotator #(.AGC_SHIFT(SH)) dut (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart),
        .tick     (tick),
        .init_re  (init_re),
        .init_im  (init_im),
        .re_coeff (re_coeff),
        .im_coeff (im_coeff),
        .power    (power),
        .out_re   (out_re),
        .out_im   (out_im),
        .valid    (valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int x);
        return x > 127 ? 127 : x < -128 ? -128 : x;
    endfunction

    function automatic int s8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    task automatic model(input logic [7:0] cr, input logic [7:0] ci, input logic [7:0] pw);
        int r, i, m, t;
        r = sat((s8(zr) * s8(cr) - s8(zi) * s8(ci) + 64) >>> 7);
        i = sat((s8(zr) * s8(ci) + s8(zi) * s8(cr) + 64) >>> 7);
        if (AGC) begin
            m = r * r + i * i;
            t = int'(pw) * 64;
            if (m < t) begin
                r = sat(r + (r >>> SH));
                i = sat(i + (i >>> SH));
            end else if (m > t) begin
                r = sat(r - (r >>> SH));
                i = sat(i - (i >>> SH));
            end
        end
        zr = 8'(r);
        zi = 8'(i);
    endtask

    task automatic do_restart(input logic [7:0] r, input logic [7:0] i);
        init_re = r;
        init_im = i;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        zr = r;
        zi = i;
        chk("restart_re", out_re, r);
        chk("restart_im", out_im, i);
        chk("restart_valid", valid, 0);
        chk("restart_overrun", overrun, 0);
    endtask

    // drives one tick, scrambles the config inputs afterwards, and checks latency, result and pulse width
    task automatic run_step(input logic [7:0] cr, input logic [7:0] ci, input logic [7:0] pw);
        int n;
        re_coeff = cr;
        im_coeff = ci;
        power = pw;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("busy_after_tick", busy, 1);
        re_coeff = 8'($urandom);
        im_coeff = 8'($urandom);
        power = 8'($urandom);
        model(cr, ci, pw);
        n = 0;
        while (!valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, LAT);
        chk("step_re", out_re, zr);
        chk("step_im", out_im, zi);
        chk("busy_at_valid", busy, 0);
        @(negedge clk);
        chk("valid_pulse", valid, 0);
    endtask

    initial begin
        int nv;
        repeat (2) @(negedge clk);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;
        @(negedge clk);

        do_restart(8'h20, 8'h00);
        run_step(8'h7d, 8'h1b, 8'h10);
        chk("dir_re", out_re, AGC ? 32'h20 : 32'h1f);
        chk("dir_im", out_im, 32'h07);

        do_restart(8'h80, 8'h00);
        run_step(8'h80, 8'h00, 8'hff);
        chk("sat_re", out_re, 32'h7f);
        chk("sat_im", out_im, 32'h00);

        do_restart(8'h40, 8'h10);
        re_coeff = 8'h70;
        im_coeff = 8'h20;
        power = 8'h40;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        model(8'h70, 8'h20, 8'h40);
        repeat (2) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        nv = 0;
        repeat (14) begin
            @(negedge clk);
            if (valid) nv++;
        end
        chk("overrun_valids", nv, 1);
        chk("overrun_flag", overrun, 1);
        chk("overrun_re", out_re, zr);
        chk("overrun_im", out_im, zi);
        do_restart(8'h33, 8'hc5);
        @(negedge clk);
        chk("restart_no_valid", valid, 0);

        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        model(8'h70, 8'h20, 8'h40);
        repeat (LAT - 1) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("edge_valid", valid, 1);
        chk("edge_overrun", overrun, 1);
        chk("edge_re", out_re, zr);
        @(negedge clk);
        chk("edge_dropped", busy, 0);

        init_re = 8'h11;
        init_im = 8'h22;
        restart = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        tick = 1'b0;
        zr = 8'h11;
        zi = 8'h22;
        chk("simul_busy", busy, 0);
        chk("simul_re", out_re, 32'h11);
        chk("simul_im", out_im, 32'h22);
        chk("simul_overrun", overrun, 0);
        nv = 0;
        repeat (10) begin
            @(negedge clk);
            if (valid || busy) nv++;
        end
        chk("simul_idle", nv, 0);

        run_step(8'h60, 8'h50, 8'h20);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_re", out_re, 0);
        chk("midrst_im", out_im, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", valid, 0);
        @(negedge clk);
        reset = 1'b0;
        zr = '0;
        zi = '0;
        nv = 0;
        repeat (10) begin
            @(negedge clk);
            if (valid || busy) nv++;
        end
        chk("midrst_quiet", nv, 0);

        for (int k = 0; k < 30; k++) begin
            if (k % 4 == 0) do_restart(8'($urandom), 8'($urandom));
            run_step(8'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
